// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and widths for the trace queue
package trace_pkg;

    typedef logic [31:0] trace_ts_t;

    localparam int DROP_CNT_W   = 16;
    localparam int TRACE_DATA_W = 32;

    // Entry layout {ts, data} at the default element width.
    typedef struct packed {
        trace_ts_t                 ts;
        logic [TRACE_DATA_W-1:0]   data;
    } trace_entry_t;

endpackage

// File: rtl/trace_queue_ram.sv
// rtl/trace_queue_ram.sv - DEPTH x W register array, one write port, async read port
module trace_queue_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Cleared on reset so the head output never carries X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trace_queue.sv
// rtl/trace_queue.sv - trace FIFO with overflow policy and drop counter; TRACE_QUEUE_TIMESTAMP_EN adds out_ts
module trace_queue
    import trace_pkg::*;
#(
    parameter int DEPTH            = 8,
    parameter int WIDTH            = 32,
    parameter int AF_LEVEL         = DEPTH - 2,
    parameter bit OVERWRITE_OLDEST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    almost_full,
    output logic                    overflow,
    input  logic                    overflow_clr,
`ifdef TRACE_QUEUE_TIMESTAMP_EN
    output trace_ts_t               out_ts,
`endif
    output logic [DROP_CNT_W-1:0]   drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef TRACE_QUEUE_TIMESTAMP_EN
    localparam int EW = $bits(trace_ts_t) + WIDTH;
`else
    localparam int EW = WIDTH;
`endif

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  af_q;
    logic                  ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0] dc_q, dc_d;
    logic                  push, pop, full, wr_en, drop;
    logic [EW-1:0]         wdata, rdata;

`ifdef TRACE_QUEUE_TIMESTAMP_EN
    trace_ts_t ts_q;

    always_ff @(posedge clk) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + 32'd1;
    end

    assign wdata    = {ts_q, in_data};
    assign out_ts   = rdata[EW-1:WIDTH];
    assign out_data = rdata[WIDTH-1:0];
`else
    assign wdata    = in_data;
    assign out_data = rdata;
`endif

    assign push = in_valid;
    assign pop  = out_valid && out_ready;
    assign full = (count_q == CW'(DEPTH));

    always_comb begin
        wr_en    = 1'b0;
        drop     = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push && pop) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else if (push && !full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            count_d  = count_q + CW'(1);
        end else if (push) begin
            // Full with no pop: either the oldest or the incoming element is lost.
            drop = 1'b1;
            if (OVERWRITE_OLDEST) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_q - CW'(1);
        end

        ovf_d = overflow_clr ? 1'b0 : (ovf_q | drop);
        if (overflow_clr)            dc_d = '0;
        else if (drop && dc_q != '1) dc_d = dc_q + DROP_CNT_W'(1);
        else                         dc_d = dc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            dc_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            af_q     <= (count_d >= CW'(AF_LEVEL));
            ovf_q    <= ovf_d;
            dc_q     <= dc_d;
        end
    end

    trace_queue_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign out_valid   = (count_q != '0);
    assign count       = count_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;
    assign drop_count  = dc_q;

endmodule

// File: tb/tb_trace_queue.sv
// tb/tb_trace_queue.sv - randomized and directed check of both overflow policies against a list model
module tb_trace_queue;

    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        overflow_clr = 1'b0;

    logic        ov_w  [2];
    logic        af_w  [2];
    logic        of_w  [2];
    logic [3:0]  cnt_w [2];
    logic [31:0] dat_w [2];
    logic [15:0] dc_w  [2];
`ifdef TRACE_QUEUE_TIMESTAMP_EN
    logic [31:0] ts_w  [2];
`endif

    trace_queue #(.DEPTH(DEPTH), .WIDTH(32), .AF_LEVEL(AF), .OVERWRITE_OLDEST(1'b1)) u_dut_ow (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_w[0]), .out_ready(out_ready), .out_data(dat_w[0]),
        .count(cnt_w[0]), .almost_full(af_w[0]), .overflow(of_w[0]),
        .overflow_clr(overflow_clr),
`ifdef TRACE_QUEUE_TIMESTAMP_EN
        .out_ts(ts_w[0]),
`endif
        .drop_count(dc_w[0])
    );

    trace_queue #(.DEPTH(DEPTH), .WIDTH(32), .AF_LEVEL(AF), .OVERWRITE_OLDEST(1'b0)) u_dut_dn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_w[1]), .out_ready(out_ready), .out_data(dat_w[1]),
        .count(cnt_w[1]), .almost_full(af_w[1]), .overflow(of_w[1]),
        .overflow_clr(overflow_clr),
`ifdef TRACE_QUEUE_TIMESTAMP_EN
        .out_ts(ts_w[1]),
`endif
        .drop_count(dc_w[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b1;

    // Reference: ordered list per instance, element 0 is the head; entries are {ts, data}.
    logic [63:0] mq [2][DEPTH];
    int          sz [2];
    bit          movf [2];
    int          mdc [2];
    logic [31:0] ts_m = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic shift_out(input int m);
        for (int i = 0; i < DEPTH - 1; i++) mq[m][i] = mq[m][i+1];
        sz[m]--;
    endtask

    task automatic model_edge(input int m, input bit ow, input bit pv, input logic [63:0] e,
                              input bit rdy, input bit clr, input bit rst);
        bit lost;
        if (rst) begin
            sz[m] = 0; movf[m] = 1'b0; mdc[m] = 0;
            return;
        end
        lost = 1'b0;
        if (sz[m] > 0 && rdy) shift_out(m);
        if (pv) begin
            if (sz[m] < DEPTH) begin
                mq[m][sz[m]] = e; sz[m]++;
            end else if (ow) begin
                shift_out(m);
                mq[m][sz[m]] = e; sz[m]++;
                lost = 1'b1;
            end else begin
                lost = 1'b1;
            end
        end
        if (clr) begin
            movf[m] = 1'b0; mdc[m] = 0;
        end else if (lost) begin
            movf[m] = 1'b1;
            if (mdc[m] < 65535) mdc[m]++;
        end
    endtask

    task automatic compare(input int m);
        check($sformatf("m%0d count", m), 64'(cnt_w[m]), 64'(sz[m]));
        check($sformatf("m%0d out_valid", m), 64'(ov_w[m]), 64'(sz[m] > 0));
        check($sformatf("m%0d almost_full", m), 64'(af_w[m]), 64'(sz[m] >= AF));
        check($sformatf("m%0d overflow", m), 64'(of_w[m]), 64'(movf[m]));
        check($sformatf("m%0d drop_count", m), 64'(dc_w[m]), 64'(mdc[m]));
        if (sz[m] > 0) begin
            check($sformatf("m%0d out_data", m), 64'(dat_w[m]), 64'(mq[m][0][31:0]));
`ifdef TRACE_QUEUE_TIMESTAMP_EN
            check($sformatf("m%0d out_ts", m), 64'(ts_w[m]), 64'(mq[m][0][63:32]));
`endif
        end
    endtask

    task automatic step(input bit pv, input logic [31:0] d, input bit rdy, input bit clr, input bit rst);
        logic [63:0] e;
        in_valid = pv; in_data = d; out_ready = rdy; overflow_clr = clr; rst_n = ~rst;
        e = {ts_m, d};
        @(posedge clk);
        model_edge(0, 1'b1, pv, e, rdy, clr, rst);
        model_edge(1, 1'b0, pv, e, rdy, clr, rst);
        ts_m = rst ? 32'd0 : ts_m + 32'd1;
        #1;
        if (chk_en) begin
            compare(0);
            compare(1);
        end
    endtask

    initial begin
        bit pv, rdy, clr;
        int pbias;

        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("reset out_data ow", 64'(dat_w[0]), 64'd0);
        check("reset out_data dn", 64'(dat_w[1]), 64'd0);

        // Three elements through with the consumer always ready.
        step(1'b1, 32'hA1, 1'b1, 1'b0, 1'b0);
        check("first head", 64'(dat_w[0]), 64'hA1);
        step(1'b1, 32'hA2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hA3, 1'b1, 1'b0, 1'b0);
        check("last head", 64'(dat_w[0]), 64'hA3);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("drained valid", 64'(ov_w[0]), 64'd0);

        // Ten pushes into an eight-entry queue, then drain.
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int v = 1; v <= 10; v++) step(1'b1, 32'(v), 1'b0, 1'b0, 1'b0);
        check("ow count full", 64'(cnt_w[0]), 64'd8);
        check("ow drops", 64'(dc_w[0]), 64'd2);
        check("ow overflow", 64'(of_w[0]), 64'd1);
        check("ow head after overflow", 64'(dat_w[0]), 64'd3);
        check("dn drops", 64'(dc_w[1]), 64'd2);
        check("dn head after overflow", 64'(dat_w[1]), 64'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Full queue with simultaneous push and pop.
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'(200 + i), 1'b1, 1'b0, 1'b0);
        check("push+pop full count", 64'(cnt_w[0]), 64'd8);
        check("push+pop full drops", 64'(dc_w[0]), 64'd0);

        // Clear coincident with a drop, then saturation.
        step(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
        check("clr wins overflow", 64'(of_w[0]), 64'd0);
        check("clr wins drop_count", 64'(dc_w[1]), 64'd0);
        step(1'b1, 32'h301, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b0;
        for (int i = 0; i < 65539; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        compare(0);
        compare(1);
        check("ow saturated", 64'(dc_w[0]), 64'hFFFF);
        check("dn saturated", 64'(dc_w[1]), 64'hFFFF);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Random traffic with phases of varying push pressure.
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            pbias = (i / 100) % 3;
            pv  = ($urandom_range(0, 3) < 32'(pbias + 1));
            rdy = ($urandom_range(0, 3) >= 32'(pbias + 1));
            clr = ($urandom_range(0, 31) == 0);
            step(pv, $urandom, rdy, clr, 1'b0);
        end

        // Reset while holding five entries and pushing.
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 32'(500 + i), 1'b0, 1'b0, 1'b0);
        check("pre-reset count", 64'(cnt_w[0]), 64'd5);
        step(1'b1, 32'hEE, 1'b0, 1'b0, 1'b1);
        check("mid reset count", 64'(cnt_w[0]), 64'd0);
        check("mid reset valid", 64'(ov_w[1]), 64'd0);
        step(1'b1, 32'hEF, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
